// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: fill/verify sequencer sitting in front of a single-port
// registered-address RAM (1-cycle read latency).
//
// Ports:
//   clock, resetn       : clock (also clocks the RAM), async active-low reset
//   start, mode, seed   : command strobe, 0=FILL / 1=VERIFY, pattern seed
//   ram_q               : RAM read data
//   address, data, write: RAM address, write data, write enable
//   busy, done          : operation in progress, one-cycle completion pulse
//   pass, err_count,
//   first_err_addr      : result of the most recent VERIFY
//
// Optional build macro RAM_SEQ_STOP_ON_ERR_EN: VERIFY aborts on the first
// mismatch instead of scanning the whole array.
`timescale 1ns/1ps

module ram_seq_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  write,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ERR_MAX   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  r_write;
    logic                  w_write_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_pass;
    logic                  w_pass_nxt;
    logic [ADDR_WIDTH:0]   r_err;
    logic [ADDR_WIDTH:0]   w_err_nxt;
    logic [ADDR_WIDTH-1:0] r_first;
    logic [ADDR_WIDTH-1:0] w_first_nxt;
    logic [DATA_WIDTH-1:0] r_seed;
    logic [DATA_WIDTH-1:0] w_seed_nxt;

    // Address issued last cycle; its data is on ram_q this cycle.
    logic [ADDR_WIDTH-1:0] r_prev_addr;
    logic [ADDR_WIDTH-1:0] w_prev_addr_nxt;
    logic                  r_prev_vld;
    logic                  w_prev_vld_nxt;

    logic [DATA_WIDTH-1:0] w_exp;
    logic                  w_mis;
    logic [ADDR_WIDTH:0]   w_err_upd;
    logic [ADDR_WIDTH-1:0] w_first_upd;

    // Read-back compare, shared by VERIFY and DRAIN.
    always_comb begin
        w_exp       = r_seed + DATA_WIDTH'(r_prev_addr);
        w_mis       = r_prev_vld && (ram_q != w_exp);
        w_err_upd   = r_err;
        w_first_upd = r_first;
        if (w_mis) begin
            if (r_err != ERR_MAX) begin
                w_err_upd = r_err + (ADDR_WIDTH + 1)'(1);
            end
            // err_count is cleared at VERIFY start, so zero marks the first miss.
            if (r_err == '0) begin
                w_first_upd = r_prev_addr;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_write_nxt     = r_write;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_pass_nxt      = r_pass;
        w_err_nxt       = r_err;
        w_first_nxt     = r_first;
        w_seed_nxt      = r_seed;
        w_prev_addr_nxt = r_prev_addr;
        w_prev_vld_nxt  = r_prev_vld;

        unique case (r_state)
            S_IDLE: begin
                w_write_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                if (start) begin
                    w_seed_nxt     = seed;
                    w_addr_nxt     = '0;
                    w_busy_nxt     = 1'b1;
                    w_prev_vld_nxt = 1'b0;
                    if (!mode) begin
                        w_state_nxt = S_FILL;
                        w_write_nxt = 1'b1;
                        w_data_nxt  = seed;
                    end else begin
                        w_state_nxt = S_VERIFY;
                        w_err_nxt   = '0;
                        w_pass_nxt  = 1'b0;
                        w_first_nxt = '0;
                    end
                end
            end

            S_FILL: begin
                if (r_addr == LAST_ADDR) begin
                    w_state_nxt = S_DONE;
                    w_write_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
                    w_data_nxt  = r_data + DATA_WIDTH'(1);
                    w_write_nxt = 1'b1;
                end
            end

            S_VERIFY: begin
                w_write_nxt     = 1'b0;
                w_prev_addr_nxt = r_addr;
                w_prev_vld_nxt  = 1'b1;
                w_err_nxt       = w_err_upd;
                w_first_nxt     = w_first_upd;
`ifdef RAM_SEQ_STOP_ON_ERR_EN
                if (w_mis) begin
                    // Abort: hold the address so no further reads are issued.
                    w_state_nxt    = S_DONE;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_pass_nxt     = 1'b0;
                    w_prev_vld_nxt = 1'b0;
                end else if (r_addr == LAST_ADDR) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
`else
                if (r_addr == LAST_ADDR) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
`endif
            end

            S_DRAIN: begin
                // Last word returns one cycle after the final address.
                w_state_nxt    = S_DONE;
                w_busy_nxt     = 1'b0;
                w_done_nxt     = 1'b1;
                w_prev_vld_nxt = 1'b0;
                w_err_nxt      = w_err_upd;
                w_first_nxt    = w_first_upd;
                w_pass_nxt     = (w_err_upd == '0);
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_write_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_write_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_write     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_first     <= '0;
            r_seed      <= '0;
            r_prev_addr <= '0;
            r_prev_vld  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_write     <= w_write_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_err       <= w_err_nxt;
            r_first     <= w_first_nxt;
            r_seed      <= w_seed_nxt;
            r_prev_addr <= w_prev_addr_nxt;
            r_prev_vld  <= w_prev_vld_nxt;
        end
    end

    assign address        = r_addr;
    assign data           = r_data;
    assign write          = r_write;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_err_addr = r_first;

endmodule
